display_formatter: RTL and testbench

Parametrised successor to the fixed 4-digit pre-display stage. It takes an unsigned fixed-point magnitude with a sign flag and converts it to BCD with a sequential double-dabble engine. It then formats the result for an N-digit seven-segment display: minus sign, leading blanks, trailing-zero trimming, decimal-point placement and overflow flag. It sits between the arithmetic core and the segment scan/decoder, with a valid/ready input handshake and a done pulse on output.

---
 rtl/display_pkg.sv | 20 ++
 rtl/bin2bcd_seq.sv | 84 ++++++++
 rtl/display_formatter.sv | 239 +++++++++++++++++++++++
 tb/tb_display_formatter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared constants and types for the seven-segment display formatter.
//   CODE_*   : digit codes driven onto seg_codes beyond plain decimal digits
//   state_e  : control FSM states of display_formatter
//   bcd_digit_t : one packed BCD digit
package display_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t CODE_BLANK = 4'd10;
  localparam bcd_digit_t CODE_MINUS = 4'd11;
  localparam bcd_digit_t CODE_ERR   = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_ROUND   = 2'd2,
    ST_FORMAT  = 2'd3
  } state_e;

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble binary to BCD converter, one bit per cycle.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start_i    : load data_i and begin (ignored while busy)
//   data_i     : binary magnitude
//   busy_o     : conversion in progress
//   done_o     : one-cycle pulse, bcd_o valid from this cycle until next start
//   bcd_o      : BCD result, digit k in bits [4k+3:4k]
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int unsigned DATA_W     = 25,
  parameter int unsigned BCD_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [DATA_W-1:0]       data_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*BCD_DIGITS-1:0] bcd_o
);

  localparam int unsigned BCD_W = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BCD_W-1:0]  adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Add-3 correction on every digit >= 5, then shift {bcd, bin} left by one.
  always_comb begin
    adj = bcd_q;
    for (int unsigned k = 0; k < BCD_DIGITS; k++) begin
      bcd_digit_t dig;
      dig = bcd_q[4*k +: 4];
      if (dig >= 4'd5) adj[4*k +: 4] = dig + 4'd3;
    end

    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;

    if (busy_q) begin
      {bcd_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
      cnt_d          = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start_i) begin
      bin_d  = data_i;
      bcd_d  = '0;
      cnt_d  = CNT_W'(DATA_W);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/display_formatter.sv
// display_formatter: converts a signed fixed-point magnitude (value = data / 10^FRAC_DIGITS)
// to NUM_DIGITS seven-segment digit codes with sign, blanking, trailing-zero trim,
// decimal point and overflow indication.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   in_valid   : data/neg valid;  in_ready : idle and accepting
//   data, neg  : unsigned magnitude and sign (1 = negative)
//   seg_codes  : digit codes, leftmost position in MSBs (0-9, 10 blank, 11 minus, 12 'E')
//   dp_pos     : one-hot decimal point, bit i = right of position i (0 = rightmost)
//   reg_neg    : displayed sign;  ovf : integer part does not fit
//   done       : one-cycle pulse when the outputs update
// Build option: define DISPLAY_ROUND_EN to round half-up at the last shown digit
// (adds a ROUND state, one extra cycle of latency).
module display_formatter
  import display_pkg::*;
#(
  parameter int unsigned DATA_W      = 25,
  parameter int unsigned FRAC_DIGITS = 3,
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned BCD_DIGITS  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       data,
  input  logic                    neg,
  output logic [4*NUM_DIGITS-1:0] seg_codes,
  output logic [NUM_DIGITS-1:0]   dp_pos,
  output logic                    reg_neg,
  output logic                    ovf,
  output logic                    done
);

  localparam int unsigned BCD_W = 4 * BCD_DIGITS;
  localparam int unsigned SEG_W = 4 * NUM_DIGITS;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              neg_q, neg_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  logic              reg_neg_q, reg_neg_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic              accept;
  logic              conv_busy, conv_done;
  logic [BCD_W-1:0]  conv_bcd;
  logic [BCD_W-1:0]  fmt_bcd;

  // Integer digit count without leading zeros, at least 1.
  function automatic int unsigned int_digits(input logic [BCD_W-1:0] b);
    int unsigned n;
    n = 1;
    for (int unsigned k = FRAC_DIGITS; k < BCD_DIGITS; k++)
      if (b[4*k +: 4] != 4'd0) n = k - FRAC_DIGITS + 1;
    return n;
  endfunction

  // Overflow and shown-fraction count for a BCD value with the given effective sign.
  function automatic void analyse(input logic [BCD_W-1:0] b, input logic sgn,
                                  output logic ov, output int unsigned s);
    int unsigned idig, fdig, p;
    logic        found;
    idig  = int_digits(b);
    fdig  = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < FRAC_DIGITS; k++) begin
      if (!found && b[4*k +: 4] != 4'd0) begin
        fdig  = FRAC_DIGITS - k;
        found = 1'b1;
      end
    end
    p  = NUM_DIGITS - 32'(sgn);
    ov = idig > p;
    s  = 0;
    if (!ov) s = (fdig < p - idig) ? fdig : p - idig;
  endfunction

  assign accept = in_valid && in_ready_q && !conv_busy;

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept),
    .data_i  (data),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

`ifdef DISPLAY_ROUND_EN
  logic [BCD_W-1:0] rbcd_q, rbcd_d;

  // Drop digits below the last shown one; add one there if the first dropped digit >= 5.
  function automatic logic [BCD_W-1:0] round_bcd(input logic [BCD_W-1:0] b, input logic sgn);
    logic [BCD_W-1:0] r;
    logic             ov, carry;
    logic [4:0]       t;
    int unsigned      s, keep;
    r = b;
    analyse(b, sgn, ov, s);
    if (!ov && s < FRAC_DIGITS) begin
      keep  = FRAC_DIGITS - s;
      carry = 1'b0;
      for (int unsigned k = 0; k < BCD_DIGITS; k++) begin
        if (k + 1 == keep) carry = (b[4*k +: 4] >= 4'd5);
        if (k < keep) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          t = {1'b0, r[4*k +: 4]} + {4'd0, carry};
          if (t > 5'd9) begin
            r[4*k +: 4] = 4'd0;
            carry       = 1'b1;
          end else begin
            r[4*k +: 4] = t[3:0];
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    rbcd_d = rbcd_q;
    if (state_q == ST_ROUND) rbcd_d = round_bcd(conv_bcd, neg_q && (conv_bcd != '0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rbcd_q <= '0;
    else        rbcd_q <= rbcd_d;
  end

  assign fmt_bcd = rbcd_q;
`else
  assign fmt_bcd = conv_bcd;
`endif

  // Display image of fmt_bcd; registered only in FORMAT.
  logic              f_sgn, f_ovf;
  int unsigned       f_idig, f_s;
  logic [BCD_W-1:0]  f_shift;
  logic [SEG_W-1:0]  f_seg;
  logic [NUM_DIGITS-1:0] f_dp;

  always_comb begin
    f_sgn  = neg_q && (fmt_bcd != '0);
    analyse(fmt_bcd, f_sgn, f_ovf, f_s);
    f_idig = int_digits(fmt_bcd);
    // Align so the lowest shown digit lands at position 0.
    f_shift = fmt_bcd >> (4 * (FRAC_DIGITS - f_s));
    f_seg   = {NUM_DIGITS{CODE_BLANK}};
    f_dp    = '0;
    if (f_ovf) begin
      f_seg = {NUM_DIGITS{CODE_ERR}};
    end else begin
      for (int unsigned p = 0; p < NUM_DIGITS; p++)
        if (p < f_idig + f_s) f_seg[4*p +: 4] = f_shift[4*p +: 4];
      if (f_sgn) f_seg[4*(NUM_DIGITS-1) +: 4] = CODE_MINUS;
      if (f_s != 0) f_dp = NUM_DIGITS'(1) << f_s;
    end
  end

  // Control FSM: IDLE -> CONVERT -> [ROUND] -> FORMAT -> IDLE.
  always_comb begin
    state_d   = state_q;
    neg_d     = neg_q;
    seg_d     = seg_q;
    dp_d      = dp_q;
    reg_neg_d = reg_neg_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_CONVERT;
          neg_d   = neg;
        end
      end
      ST_CONVERT: begin
        if (conv_done) begin
`ifdef DISPLAY_ROUND_EN
          state_d = ST_ROUND;
`else
          state_d = ST_FORMAT;
`endif
        end
      end
      ST_ROUND: state_d = ST_FORMAT;
      ST_FORMAT: begin
        state_d   = ST_IDLE;
        seg_d     = f_seg;
        dp_d      = f_dp;
        reg_neg_d = f_sgn;
        ovf_d     = f_ovf;
        done_d    = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      neg_q      <= 1'b0;
      seg_q      <= {NUM_DIGITS{CODE_BLANK}};
      dp_q       <= '0;
      reg_neg_q  <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      neg_q      <= neg_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      reg_neg_q  <= reg_neg_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign seg_codes = seg_q;
  assign dp_pos    = dp_q;
  assign reg_neg   = reg_neg_q;
  assign ovf       = ovf_q;
  assign done      = done_q;

endmodule

// File: tb/tb_display_formatter.sv
// tb_display_formatter: directed table, random-vs-model, back-to-back and reset-abort checks
// for display_formatter. Define DISPLAY_ROUND_EN to exercise the rounding build.
module tb_display_formatter;

  localparam int unsigned DATA_W      = 25;
  localparam int unsigned FRAC_DIGITS = 3;
  localparam int unsigned NUM_DIGITS  = 4;
  localparam int unsigned BCD_DIGITS  = 8;
  localparam int unsigned SEG_W       = 4 * NUM_DIGITS;
`ifdef DISPLAY_ROUND_EN
  localparam int unsigned LAT = DATA_W + 3;
  localparam bit          RND = 1'b1;
`else
  localparam int unsigned LAT = DATA_W + 2;
  localparam bit          RND = 1'b0;
`endif
  localparam int unsigned PERIOD = LAT + 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [DATA_W-1:0]     data = '0;
  logic                  neg = 1'b0;
  logic [SEG_W-1:0]      seg_codes;
  logic [NUM_DIGITS-1:0] dp_pos;
  logic                  reg_neg, ovf, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  display_formatter #(
    .DATA_W(DATA_W), .FRAC_DIGITS(FRAC_DIGITS), .NUM_DIGITS(NUM_DIGITS), .BCD_DIGITS(BCD_DIGITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .data(data), .neg(neg),
    .seg_codes(seg_codes), .dp_pos(dp_pos), .reg_neg(reg_neg), .ovf(ovf), .done(done)
  );

  typedef struct {
    logic [SEG_W-1:0]      seg;
    logic [NUM_DIGITS-1:0] dp;
    logic                  rneg;
    logic                  ovf;
  } res_t;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              n;
    res_t              exp;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_res(input string tag, input res_t e);
    check({tag, "_seg"}, longint'(seg_codes), longint'(e.seg));
    check({tag, "_dp"},  longint'(dp_pos),    longint'(e.dp));
    check({tag, "_neg"}, longint'(reg_neg),   longint'(e.rneg));
    check({tag, "_ovf"}, longint'(ovf),       longint'(e.ovf));
  endtask

  function automatic longint unsigned pow10(input int unsigned e);
    longint unsigned r = 1;
    for (int unsigned i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  // Decimal view of a value: sign shown, integer digits, shown fraction, overflow.
  function automatic void measure(input longint unsigned v, input bit n, output bit sg,
                                  output int unsigned idig, output int unsigned s, output bit ov);
    longint unsigned ip, fp, t;
    int unsigned     fdig, p;
    ip   = v / pow10(FRAC_DIGITS);
    fp   = v % pow10(FRAC_DIGITS);
    idig = 1;
    t    = ip;
    while (t >= 10) begin t = t / 10; idig++; end
    fdig = 0;
    if (fp != 0) begin
      fdig = FRAC_DIGITS;
      t    = fp;
      while (t % 10 == 0) begin t = t / 10; fdig--; end
    end
    sg = n && (v != 0);
    p  = NUM_DIGITS - (sg ? 1 : 0);
    ov = idig > p;
    s  = ov ? 0 : ((fdig < p - idig) ? fdig : p - idig);
  endfunction

  function automatic res_t model(input logic [DATA_W-1:0] d, input bit n);
    res_t            r;
    longint unsigned v, unit, q, shown;
    bit              sg, ov;
    int unsigned     idig, s;
    v = longint'(d);
    measure(v, n, sg, idig, s, ov);
    if (RND && !ov && s < FRAC_DIGITS) begin
      unit = pow10(FRAC_DIGITS - s);
      q    = v / unit;
      if ((v % unit) / (unit / 10) >= 5) q++;
      v = q * unit;
      measure(v, n, sg, idig, s, ov);
    end
    r.rneg = sg;
    r.ovf  = ov;
    r.dp   = '0;
    if (ov) begin
      r.seg = {NUM_DIGITS{4'd12}};
    end else begin
      r.seg = {NUM_DIGITS{4'd10}};
      shown = v / pow10(FRAC_DIGITS - s);
      for (int unsigned p = 0; p < idig + s; p++)
        r.seg[4*p +: 4] = 4'((shown / pow10(p)) % 10);
      if (sg) r.seg[SEG_W-4 +: 4] = 4'd11;
      if (s != 0) r.dp[s] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    case ($urandom_range(0, 3))
      0:       return DATA_W'($urandom_range(0, 9999));
      1:       return DATA_W'($urandom_range(0, 9999999));
      2:       return DATA_W'($urandom_range(0, 9999) * 1000);
      default: return DATA_W'($urandom);
    endcase
  endfunction

  // Waits (bounded) at negedges for in_ready.
  task automatic wait_ready(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 4 * PERIOD; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    check({tag, "_ready_timeout"}, longint'(ok), 1);
  endtask

  // One transaction: accept, scramble inputs while busy, check latency, outputs and pulse width.
  task automatic run_op(input logic [DATA_W-1:0] d, input logic n, input string tag, input res_t e);
    int lat = -1;
    wait_ready(tag);
    data     = d;
    neg      = n;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data     = rnd_data();
    neg      = ~n;
    for (int cyc = 1; cyc <= int'(LAT) + 8; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin lat = cyc; break; end
    end
    check({tag, "_latency"}, longint'(lat), longint'(LAT));
    if (lat > 0) begin
      check_res(tag, e);
      @(negedge clk);
      check({tag, "_done_pulse"}, longint'(done), 0);
    end
  endtask

  initial begin
    vec_t vecs[$];
    res_t nonr;

    vecs.push_back('{d: 25'd12345,    n: 1'b0, exp: '{seg: (RND ? 16'h1235 : 16'h1234), dp: 4'b0100, rneg: 1'b0, ovf: 1'b0}});
    vecs.push_back('{d: 25'd1500,     n: 1'b1, exp: '{seg: 16'hBA15, dp: 4'b0010, rneg: 1'b1, ovf: 1'b0}});
    vecs.push_back('{d: 25'd5000,     n: 1'b1, exp: '{seg: 16'hBAA5, dp: 4'b0000, rneg: 1'b1, ovf: 1'b0}});
    vecs.push_back('{d: 25'd10000000, n: 1'b0, exp: '{seg: 16'hCCCC, dp: 4'b0000, rneg: 1'b0, ovf: 1'b1}});
    vecs.push_back('{d: 25'd0,        n: 1'b1, exp: '{seg: 16'hAAA0, dp: 4'b0000, rneg: 1'b0, ovf: 1'b0}});
    vecs.push_back('{d: 25'd1,        n: 1'b0, exp: '{seg: 16'h0001, dp: 4'b1000, rneg: 1'b0, ovf: 1'b0}});
    vecs.push_back('{d: 25'd50,       n: 1'b1, exp: '{seg: 16'hB005, dp: 4'b0100, rneg: 1'b1, ovf: 1'b0}});
    vecs.push_back('{d: 25'd1234567,  n: 1'b1, exp: '{seg: 16'hCCCC, dp: 4'b0000, rneg: 1'b1, ovf: 1'b1}});
    vecs.push_back('{d: 25'd123456,   n: 1'b1, exp: '{seg: 16'hB123, dp: 4'b0000, rneg: 1'b1, ovf: 1'b0}});
    vecs.push_back('{d: 25'd33554431, n: 1'b0, exp: '{seg: 16'hCCCC, dp: 4'b0000, rneg: 1'b0, ovf: 1'b1}});
`ifdef DISPLAY_ROUND_EN
    vecs.push_back('{d: 25'd9999,     n: 1'b1, exp: '{seg: 16'hBA10, dp: 4'b0000, rneg: 1'b1, ovf: 1'b0}});
    vecs.push_back('{d: 25'd9999999,  n: 1'b0, exp: '{seg: 16'hCCCC, dp: 4'b0000, rneg: 1'b0, ovf: 1'b1}});
`else
    vecs.push_back('{d: 25'd9999,     n: 1'b1, exp: '{seg: 16'hB999, dp: 4'b0100, rneg: 1'b1, ovf: 1'b0}});
    vecs.push_back('{d: 25'd9999999,  n: 1'b0, exp: '{seg: 16'h9999, dp: 4'b0000, rneg: 1'b0, ovf: 1'b0}});
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_res("reset", '{seg: 16'hAAAA, dp: 4'b0000, rneg: 1'b0, ovf: 1'b0});
    check("reset_done", longint'(done), 0);
    check("reset_ready", longint'(in_ready), 0);
    rst_n = 1'b1;

    // Directed table.
    foreach (vecs[i]) run_op(vecs[i].d, vecs[i].n, $sformatf("vec%0d", i), vecs[i].exp);

    // Random against the model.
    for (int i = 0; i < 20; i++) begin
      logic [DATA_W-1:0] d = rnd_data();
      logic              n = 1'($urandom_range(0, 1));
      run_op(d, n, $sformatf("rand%0d_d%0d_n%0d", i, d, n), model(d, n));
    end

    // in_valid held high: one accept per PERIOD, data sampled only at accept.
    begin
      logic [DATA_W-1:0] qd[$];
      bit                qn[$];
      int                last_acc = -1, last_done = -1, ndone = 0;
      bit                drained = 1'b0;
      wait_ready("cont");
      in_valid = 1'b1;
      for (int cyc = 0; cyc < 3 * int'(PERIOD) + 4; cyc++) begin
        data = rnd_data();
        neg  = 1'($urandom_range(0, 1));
        if (in_ready) begin
          if (last_acc >= 0) check("cont_accept_spacing", longint'(cyc - last_acc), longint'(PERIOD));
          last_acc = cyc;
          qd.push_back(data);
          qn.push_back(neg);
        end
        @(posedge clk);
        @(negedge clk);
        if (done) begin
          ndone++;
          if (last_done >= 0) check("cont_done_spacing", longint'(cyc - last_done), longint'(PERIOD));
          else                check("cont_first_latency", longint'(cyc), longint'(LAT));
          last_done = cyc;
          check("cont_queue_nonempty", longint'(qd.size() > 0), 1);
          if (qd.size() > 0) check_res($sformatf("cont%0d", ndone), model(qd.pop_front(), qn.pop_front()));
        end
      end
      in_valid = 1'b0;
      check("cont_done_count", longint'(ndone), 3);
      for (int cyc = 0; cyc < int'(PERIOD) + 4; cyc++) begin
        @(posedge clk);
        @(negedge clk);
        if (done) begin
          drained = 1'b1;
          if (qd.size() > 0) check_res("cont_drain", model(qd.pop_front(), qn.pop_front()));
          break;
        end
      end
      check("cont_drain_done", longint'(drained), 1);
    end

    // Reset pulse mid-CONVERT aborts the operation and clears outputs.
    begin
      int seen = 0;
      nonr = model(25'd1500, 1'b1);
      run_op(25'd1500, 1'b1, "pre_reset", nonr);
      wait_ready("abort");
      data     = 25'd12345;
      neg      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_res("abort", '{seg: 16'hAAAA, dp: 4'b0000, rneg: 1'b0, ovf: 1'b0});
      check("abort_done", longint'(done), 0);
      check("abort_ready_low", longint'(in_ready), 0);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_ready_back", longint'(in_ready), 1);
      for (int cyc = 0; cyc < int'(LAT) + 4; cyc++) begin
        if (done) seen++;
        @(posedge clk);
        @(negedge clk);
      end
      check("abort_no_done", longint'(seen), 0);
      check_res("abort_hold", '{seg: 16'hAAAA, dp: 4'b0000, rneg: 1'b0, ovf: 1'b0});
      run_op(25'd9999, 1'b1, "post_reset", model(25'd9999, 1'b1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
